// File: rtl/regbank_pkg.sv
// Shared constants and dump FSM state encoding for the DLX general-purpose register bank.
package regbank_pkg;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int N_REGS  = 2 ** NB_REG;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regbank_if.sv
// Register bank bus: WB write triple, ID read ports and the debug dump channel.
interface regbank_if #(
    parameter int NB_DATA = regbank_pkg::NB_DATA,
    parameter int NB_REG  = regbank_pkg::NB_REG
);

    logic               i_enable;
    logic               i_WB_reg_write;
    logic [NB_REG-1:0]  i_WB_selected_reg;
    logic [NB_DATA-1:0] i_WB_selected_data;
    logic [NB_REG-1:0]  i_ID_rs;
    logic [NB_REG-1:0]  i_ID_rt;
    logic [NB_DATA-1:0] o_ID_rs_data;
    logic [NB_DATA-1:0] o_ID_rt_data;
    logic               i_dump_start;
    logic               i_dump_ready;
    logic               o_dump_valid;
    logic [NB_REG-1:0]  o_dump_addr;
    logic [NB_DATA-1:0] o_dump_data;
    logic               o_dump_last;
    logic               o_dump_busy;

    modport master (
        output i_enable, i_WB_reg_write, i_WB_selected_reg, i_WB_selected_data,
        output i_ID_rs, i_ID_rt, i_dump_start, i_dump_ready,
        input  o_ID_rs_data, o_ID_rt_data, o_dump_valid, o_dump_addr,
        input  o_dump_data, o_dump_last, o_dump_busy
    );

    modport slave (
        input  i_enable, i_WB_reg_write, i_WB_selected_reg, i_WB_selected_data,
        input  i_ID_rs, i_ID_rt, i_dump_start, i_dump_ready,
        output o_ID_rs_data, o_ID_rt_data, o_dump_valid, o_dump_addr,
        output o_dump_data, o_dump_last, o_dump_busy
    );

endinterface

// File: rtl/regbank_dump_fsm.sv
// Dump sequencer: walks register indices 0..N_REGS-1 over a valid/ready channel,
// one beat per handshake, and tells the bank when to (re)load the beat data register.
module regbank_dump_fsm #(
    parameter int NB_REG = regbank_pkg::NB_REG
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              start_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic              last_o,
    output logic              busy_o,
    output logic [NB_REG-1:0] idx_o,
    output logic              load_o,
    output logic [NB_REG-1:0] load_idx_o
);

    import regbank_pkg::*;

    localparam logic [NB_REG-1:0] LAST_IDX = {NB_REG{1'b1}};

    dump_state_e       state_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic [NB_REG-1:0] idx_q;
    logic              hs;

    assign hs         = valid_q & ready_i;
    assign load_o     = ((state_q == IDLE) & start_i) | ((state_q == SEND) & hs & (idx_q != LAST_IDX));
    assign load_idx_o = (state_q == IDLE) ? '0 : idx_q + 1'b1;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                            idx_q   <= '0;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            last_q <= (idx_q == LAST_IDX - 1'b1);
                        end
                    end
                end
            endcase
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/register_bank.sv
// 32-entry DLX GPR file: WB write port, two combinational ID read ports, debug dump stream.
// Define REGBANK_WRITE_BYPASS_EN to make reads write-through on a same-cycle write.
module register_bank #(
    parameter int NB_DATA = regbank_pkg::NB_DATA,
    parameter int NB_REG  = regbank_pkg::NB_REG
) (
    input  logic      i_clock,
    input  logic      i_reset,
    regbank_if.slave  bus
);

    localparam int N_REGS = 2 ** NB_REG;

    import regbank_pkg::*;

    logic [NB_DATA-1:0] regs_q [N_REGS];
    logic [NB_DATA-1:0] dump_data_q;
    logic [NB_DATA-1:0] load_val;
    logic [NB_DATA-1:0] rs_val;
    logic [NB_DATA-1:0] rt_val;
    logic               wr_en;
    logic               load;
    logic [NB_REG-1:0]  load_idx;
    logic [NB_REG-1:0]  dump_idx;

    // Register 0 is hardwired: never written, so it keeps its reset value of zero.
    assign wr_en = bus.i_enable & bus.i_WB_reg_write & (bus.i_WB_selected_reg != '0);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.i_WB_selected_reg] <= bus.i_WB_selected_data;
        end
    end

    always_comb begin
        rs_val = regs_q[bus.i_ID_rs];
        rt_val = regs_q[bus.i_ID_rt];
`ifdef REGBANK_WRITE_BYPASS_EN
        if (wr_en && (bus.i_ID_rs == bus.i_WB_selected_reg)) rs_val = bus.i_WB_selected_data;
        if (wr_en && (bus.i_ID_rt == bus.i_WB_selected_reg)) rt_val = bus.i_WB_selected_data;
`endif
    end

    assign bus.o_ID_rs_data = rs_val;
    assign bus.o_ID_rt_data = rt_val;

    regbank_dump_fsm #(
        .NB_REG (NB_REG)
    ) u_dump_fsm (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .start_i    (bus.i_dump_start),
        .ready_i    (bus.i_dump_ready),
        .valid_o    (bus.o_dump_valid),
        .last_o     (bus.o_dump_last),
        .busy_o     (bus.o_dump_busy),
        .idx_o      (dump_idx),
        .load_o     (load),
        .load_idx_o (load_idx)
    );

    // A load coinciding with a write to the same index captures the value being written.
    assign load_val = (wr_en && (bus.i_WB_selected_reg == load_idx)) ? bus.i_WB_selected_data
                                                                      : regs_q[load_idx];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            dump_data_q <= '0;
        end else if (load) begin
            dump_data_q <= load_val;
        end
    end

    assign bus.o_dump_addr = dump_idx;
    assign bus.o_dump_data = dump_data_q;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus queues expected reads and dump beats,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_register_bank;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        bit          st;
    } rd_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_strobe;
    logic [31:0] mdl [32];
    rd_t         rd_q [$];
    beat_t       dq [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    regbank_if #(.NB_DATA(32), .NB_REG(5)) bus ();

    register_bank #(.NB_DATA(32), .NB_REG(5)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: reads are checked when strobed, dump beats whenever valid is presented.
    always @(negedge clk) begin
        rd_t   r;
        beat_t b;
        if (rd_strobe) begin
            if (rd_q.size() == 0) begin
                fail("rd_q_underflow");
            end else begin
                r = rd_q.pop_front();
                check("rs_data", bus.o_ID_rs_data, r.rs);
                check("rt_data", bus.o_ID_rt_data, r.rt);
                if (r.st) begin
                    check("dump_valid_idle", {31'd0, bus.o_dump_valid}, 32'd0);
                    check("dump_busy_idle", {31'd0, bus.o_dump_busy}, 32'd0);
                end
            end
        end
        if (bus.o_dump_valid === 1'b1) begin
            if (dq.size() == 0) begin
                fail("unexpected_beat");
            end else begin
                b = dq[0];
                if (bus.i_dump_ready) begin
                    void'(dq.pop_front());
                    check("beat_addr", {27'd0, bus.o_dump_addr}, {27'd0, b.addr});
                    check("beat_data", bus.o_dump_data, b.data);
                    check("beat_last", {31'd0, bus.o_dump_last}, {31'd0, b.last});
                end else begin
                    check("hold_addr", {27'd0, bus.o_dump_addr}, {27'd0, b.addr});
                    check("hold_data", bus.o_dump_data, b.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] ers, input logic [31:0] ert, input bit st);
        rd_t r;
        bus.i_ID_rs = rs;
        bus.i_ID_rt = rt;
        r.rs = ers;
        r.rt = ert;
        r.st = st;
        rd_q.push_back(r);
        rd_strobe = 1'b1;
        step();
        rd_strobe = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
        bus.i_enable           = en;
        bus.i_WB_reg_write     = 1'b1;
        bus.i_WB_selected_reg  = a;
        bus.i_WB_selected_data = d;
        step();
        if (en && a != 5'd0) mdl[a] = d;
        bus.i_WB_reg_write = 1'b0;
        bus.i_enable       = 1'b1;
    endtask

    task automatic push_dump();
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.addr = 5'(i);
            b.data = mdl[i];
            b.last = (i == 31);
            dq.push_back(b);
        end
    endtask

    task automatic pulse_start();
        bus.i_dump_start = 1'b1;
        step();
        bus.i_dump_start = 1'b0;
    endtask

    initial begin
        int  bud;
        bit  pulsed;
        logic [31:0] exp_byp;

        rst_n                  = 1'b0;
        rd_strobe              = 1'b0;
        bus.i_enable           = 1'b1;
        bus.i_WB_reg_write     = 1'b0;
        bus.i_WB_selected_reg  = '0;
        bus.i_WB_selected_data = '0;
        bus.i_ID_rs            = '0;
        bus.i_ID_rt            = '0;
        bus.i_dump_start       = 1'b0;
        bus.i_dump_ready       = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int a = 0; a < 32; a++) rd_chk(5'(a), 5'(31 - a), 32'd0, 32'd0, 1'b1);

        // 2: basic write, r0 write ignored
        wr(5'd5, 32'hDEADBEEF, 1'b1);
        rd_chk(5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0);
        wr(5'd0, 32'h0000_1234, 1'b1);
        rd_chk(5'd0, 5'd5, 32'd0, 32'hDEADBEEF, 1'b0);

        // 3: enable gates writes
        wr(5'd7, 32'h55, 1'b0);
        rd_chk(5'd7, 5'd7, 32'd0, 32'd0, 1'b0);
        wr(5'd7, 32'h55, 1'b1);
        rd_chk(5'd7, 5'd5, 32'h55, 32'hDEADBEEF, 1'b0);

        // 4: same-cycle write and read of r3
`ifdef REGBANK_WRITE_BYPASS_EN
        exp_byp = 32'hAA;
`else
        exp_byp = 32'h0;
`endif
        bus.i_enable           = 1'b1;
        bus.i_WB_reg_write     = 1'b1;
        bus.i_WB_selected_reg  = 5'd3;
        bus.i_WB_selected_data = 32'hAA;
        rd_chk(5'd0, 5'd3, 32'd0, exp_byp, 1'b0);
        bus.i_WB_reg_write = 1'b0;
        mdl[3] = 32'hAA;
        rd_chk(5'd3, 5'd3, 32'hAA, 32'hAA, 1'b0);

        // 5: full dump at ready=1, with a start pulse mid-dump that must be ignored
        for (int n = 1; n < 32; n++) wr(5'(n), 32'(n) * 32'h11, 1'b1);
        push_dump();
        bus.i_dump_ready = 1'b1;
        pulse_start();
        bud = 200;
        pulsed = 1'b0;
        while (dq.size() != 0 && bud > 0) begin
            if (!pulsed && bus.o_dump_valid && bus.o_dump_addr == 5'd10) begin
                bus.i_dump_start = 1'b1;
                pulsed = 1'b1;
            end
            step();
            bus.i_dump_start = 1'b0;
            bud--;
        end
        if (bud == 0) fail("dump5_timeout");
        rd_chk(5'd31, 5'd1, 32'h0000_020F, 32'h11, 1'b1);

        // 6: stall on beat 4 while r4 is rewritten, then reset at beat 10
        push_dump();
        pulse_start();
        bud = 100;
        while (!(bus.o_dump_valid && bus.o_dump_addr == 5'd4) && bud > 0) begin
            step();
            bud--;
        end
        if (bud == 0) fail("beat4_timeout");
        bus.i_dump_ready = 1'b0;
        wr(5'd4, 32'hCAFE0004, 1'b1);
        step();
        step();
        bus.i_dump_ready = 1'b1;
        bud = 100;
        while (!(bus.o_dump_valid && bus.o_dump_addr == 5'd10) && bud > 0) begin
            step();
            bud--;
        end
        if (bud == 0) fail("beat10_timeout");
        rst_n = 1'b0;
        dq.delete();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        rd_chk(5'd4, 5'd5, 32'd0, 32'd0, 1'b1);
        rst_n = 1'b1;
        step();

        // restart from addr 0; r2 written on the same edge its beat is loaded
        wr(5'd1, 32'h111, 1'b1);
        wr(5'd31, 32'hF0F0F0F0, 1'b1);
        mdl[2] = 32'h2222;
        push_dump();
        pulse_start();
        bud = 200;
        pulsed = 1'b0;
        while (dq.size() != 0 && bud > 0) begin
            if (!pulsed && bus.o_dump_valid && bus.o_dump_addr == 5'd1) begin
                bus.i_enable           = 1'b1;
                bus.i_WB_reg_write     = 1'b1;
                bus.i_WB_selected_reg  = 5'd2;
                bus.i_WB_selected_data = 32'h2222;
                pulsed = 1'b1;
            end
            step();
            bus.i_WB_reg_write = 1'b0;
            bud--;
        end
        if (bud == 0) fail("dump6_timeout");
        rd_chk(5'd2, 5'd4, 32'h2222, 32'd0, 1'b1);

        step();
        check("dq_drained", dq.size(), 32'd0);
        check("rd_q_drained", rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
